// File: rtl/sap1_pkg.sv
// SAP-1 controller shared definitions: opcodes, one-hot T-states,
// control-word bit positions and small decode helpers.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int T_W = 6;
  localparam logic [T_W-1:0] T1_OH = 6'b000001;
  localparam logic [T_W-1:0] T2_OH = 6'b000010;
  localparam logic [T_W-1:0] T3_OH = 6'b000100;
  localparam logic [T_W-1:0] T4_OH = 6'b001000;
  localparam logic [T_W-1:0] T5_OH = 6'b010000;
  localparam logic [T_W-1:0] T6_OH = 6'b100000;

  // Control word {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo}
  localparam int CON_W  = 12;
  localparam int CON_CP = 11;
  localparam int CON_EP = 10;
  localparam int CON_LM = 9;
  localparam int CON_CE = 8;
  localparam int CON_LI = 7;
  localparam int CON_EI = 6;
  localparam int CON_LA = 5;
  localparam int CON_EA = 4;
  localparam int CON_SU = 3;
  localparam int CON_EU = 2;
  localparam int CON_LB = 1;
  localparam int CON_LO = 0;

  function automatic logic [CON_W-1:0] cb(
    input int idx
  );
    logic [CON_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic op_legal(
    input logic [3:0] op
  );
    return (op == OP_LDA) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_OUT) ||
           (op == OP_HLT);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T1..T6 ring. Restart forces T1 on the next edge (early end),
// Freeze holds the current state (halt). Ports: SysClock, ClearN, Restart, Freeze, TState.
import sap1_pkg::*;

module sap1_ring_counter (
  input  logic           SysClock,
  input  logic           ClearN,
  input  logic           Restart,
  input  logic           Freeze,
  output logic [T_W-1:0] TState
);

  logic [T_W-1:0] t_q;
  logic [T_W-1:0] t_d;

  always_comb begin
    t_d = {t_q[T_W-2:0], t_q[T_W-1]};
    if (Freeze) begin
      t_d = t_q;
    end else if (Restart) begin
      t_d = T1_OH;
    end
  end

  always_ff @(posedge SysClock or negedge ClearN) begin
    if (!ClearN) begin
      t_q <= T1_OH;
    end else begin
      t_q <= t_d;
    end
  end

  assign TState = t_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: ring-counter driven control word decode,
// halt latch, sticky illegal-opcode flag and retired-instruction counter.
// Ports: SysClock, ClearN, Opcode -> Con, TState, Halt, IllegalOp, InstrCount.
import sap1_pkg::*;

module sap1_controller_sequencer #(
  parameter bit EARLY_END = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             SysClock,
  input  logic             ClearN,
  input  logic [3:0]       Opcode,
  output logic [CON_W-1:0] Con,
  output logic [T_W-1:0]   TState,
  output logic             Halt,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  logic [T_W-1:0]   t_s;
  logic             halt_q;
  logic             halt_d;
  logic             ill_q;
  logic             ill_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic is_lda;
  logic is_add;
  logic is_sub;
  logic is_out;
  logic is_hlt;
  logic legal;
  logic hlt_t4;
  logic restart;
  logic freeze;
  logic retire;

  logic [CON_W-1:0] ex4;
  logic [CON_W-1:0] ex5;
  logic [CON_W-1:0] ex6;
  logic [CON_W-1:0] con_w;

  assign is_lda = (Opcode == OP_LDA);
  assign is_add = (Opcode == OP_ADD);
  assign is_sub = (Opcode == OP_SUB);
  assign is_out = (Opcode == OP_OUT);
  assign is_hlt = (Opcode == OP_HLT);
  assign legal  = op_legal(Opcode);

  assign hlt_t4 = t_s[3] && is_hlt;

  // Early end: LDA finishes at T5, OUT and NOPs at T4.
  assign restart = EARLY_END &&
                   ((t_s[4] && is_lda) ||
                    (t_s[3] && (is_out || !legal)));

  assign freeze = halt_q || hlt_t4;

  assign retire = !halt_q &&
                  (t_s[5] || restart || hlt_t4);

  sap1_ring_counter u_ring (
    .SysClock (SysClock),
    .ClearN   (ClearN),
    .Restart  (restart),
    .Freeze   (freeze),
    .TState   (t_s)
  );

  always_comb begin
    halt_d = halt_q | hlt_t4;
    ill_d  = ill_q | (!halt_q && t_s[3] && !legal);
    cnt_d  = cnt_q + CNT_W'(retire);
  end

  always_ff @(posedge SysClock or negedge ClearN) begin
    if (!ClearN) begin
      halt_q <= 1'b0;
      ill_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      halt_q <= halt_d;
      ill_q  <= ill_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    ex4 = '0;
    ex5 = '0;
    ex6 = '0;
    if (is_lda) begin
      ex4 = cb(CON_EI) | cb(CON_LM);
      ex5 = cb(CON_CE) | cb(CON_LA);
    end else if (is_add || is_sub) begin
      ex4 = cb(CON_EI) | cb(CON_LM);
      ex5 = cb(CON_CE) | cb(CON_LB);
      ex6 = cb(CON_EU) | cb(CON_LA);
      if (is_sub) begin
        ex6 = ex6 | cb(CON_SU);
      end
    end else if (is_out) begin
      ex4 = cb(CON_EA) | cb(CON_LO);
    end
  end

  // Forced quiet while in reset or halted.
  always_comb begin
    con_w = '0;
    if (ClearN && !halt_q) begin
      unique case (1'b1)
        t_s[0]: con_w = cb(CON_EP) | cb(CON_LM);
        t_s[1]: con_w = cb(CON_CP);
        t_s[2]: con_w = cb(CON_CE) | cb(CON_LI);
        t_s[3]: con_w = ex4;
        t_s[4]: con_w = ex5;
        t_s[5]: con_w = ex6;
        default: con_w = '0;
      endcase
    end
  end

  assign Con        = con_w;
  assign TState     = t_s;
  assign Halt       = halt_q;
  assign IllegalOp  = ill_q;
  assign InstrCount = cnt_q;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Randomized bench for the SAP-1 controller with an instruction-level
// reference model; instance 0 uses the fixed 6-state cycle, instance 1 early end.
module tb_sap1_controller_sequencer;

  localparam logic [11:0] B_CP = 12'h800;
  localparam logic [11:0] B_EP = 12'h400;
  localparam logic [11:0] B_LM = 12'h200;
  localparam logic [11:0] B_CE = 12'h100;
  localparam logic [11:0] B_LI = 12'h080;
  localparam logic [11:0] B_EI = 12'h040;
  localparam logic [11:0] B_LA = 12'h020;
  localparam logic [11:0] B_EA = 12'h010;
  localparam logic [11:0] B_SU = 12'h008;
  localparam logic [11:0] B_EU = 12'h004;
  localparam logic [11:0] B_LB = 12'h002;
  localparam logic [11:0] B_LO = 12'h001;
  localparam logic [11:0] DRV  =
    B_EP | B_CE | B_EI | B_EA | B_EU;

  logic        clk = 1'b0;
  logic        clear_n [2];
  logic [3:0]  opcode  [2];
  logic [11:0] con     [2];
  logic [5:0]  ts      [2];
  logic        halt    [2];
  logic        ill     [2];
  logic [7:0]  cnt     [2];

  int          m_t     [2];
  bit          m_halt  [2];
  bit          m_ill   [2];
  logic [7:0]  m_cnt   [2];
  logic [3:0]  cur_op  [2];
  logic [3:0]  prog    [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sap1_controller_sequencer #(
    .EARLY_END (1'b0),
    .CNT_W     (8)
  ) u_dut0 (
    .SysClock   (clk),
    .ClearN     (clear_n[0]),
    .Opcode     (opcode[0]),
    .Con        (con[0]),
    .TState     (ts[0]),
    .Halt       (halt[0]),
    .IllegalOp  (ill[0]),
    .InstrCount (cnt[0])
  );

  sap1_controller_sequencer #(
    .EARLY_END (1'b1),
    .CNT_W     (8)
  ) u_dut1 (
    .SysClock   (clk),
    .ClearN     (clear_n[1]),
    .Opcode     (opcode[1]),
    .Con        (con[1]),
    .TState     (ts[1]),
    .Halt       (halt[1]),
    .IllegalOp  (ill[1]),
    .InstrCount (cnt[1])
  );

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
  endfunction

  // Number of T-states an instruction occupies.
  function automatic int last_t(
    input logic [3:0] op,
    input int         early
  );
    if (op == 4'hF) return 4;
    if (early == 0) return 6;
    if (op == 4'h0) return 5;
    if (op == 4'h1 || op == 4'h2) return 6;
    return 4;
  endfunction

  function automatic logic [11:0] exp_con(input int d);
    logic [3:0] op;
    op = cur_op[d];
    if (!clear_n[d] || m_halt[d]) return 12'h000;
    case (m_t[d])
      1: return B_EP | B_LM;
      2: return B_CP;
      3: return B_CE | B_LI;
      default: ;
    endcase
    case (op)
      4'h0: begin
        if (m_t[d] == 4) return B_EI | B_LM;
        if (m_t[d] == 5) return B_CE | B_LA;
      end
      4'h1: begin
        if (m_t[d] == 4) return B_EI | B_LM;
        if (m_t[d] == 5) return B_CE | B_LB;
        if (m_t[d] == 6) return B_EU | B_LA;
      end
      4'h2: begin
        if (m_t[d] == 4) return B_EI | B_LM;
        if (m_t[d] == 5) return B_CE | B_LB;
        if (m_t[d] == 6) return B_SU | B_EU | B_LA;
      end
      4'hE: begin
        if (m_t[d] == 4) return B_EA | B_LO;
      end
      default: ;
    endcase
    return 12'h000;
  endfunction

  task automatic model_reset(input int d);
    m_t[d]    = 1;
    m_halt[d] = 1'b0;
    m_ill[d]  = 1'b0;
    m_cnt[d]  = 8'd0;
  endtask

  task automatic model_step(input int d);
    logic [3:0] op;
    op = cur_op[d];
    if (clear_n[d] && !m_halt[d]) begin
      if (m_t[d] == 4 && op == 4'hF) begin
        m_halt[d] = 1'b1;
        m_cnt[d]  = m_cnt[d] + 8'd1;
      end else begin
        if (m_t[d] == 4 && !legal(op)) m_ill[d] = 1'b1;
        if (m_t[d] == last_t(op, d)) begin
          m_t[d]   = 1;
          m_cnt[d] = m_cnt[d] + 8'd1;
        end else begin
          m_t[d] = m_t[d] + 1;
        end
      end
    end
  endtask

  task automatic do_reset(input int d, input int n);
    clear_n[d] = 1'b0;
    model_reset(d);
    repeat (n) @(negedge clk);
    clear_n[d] = 1'b1;
    prog.delete();
  endtask

  // Feeds the program one cycle at a time and compares against the model.
  task automatic run_cycles(
    input int    d,
    input int    n,
    input string tag
  );
    logic [11:0] e_con;
    logic [5:0]  e_ts;
    for (int i = 0; i < n; i++) begin
      if (m_halt[d] || m_t[d] < 3) begin
        opcode[d] = 4'($urandom);
      end else begin
        if (m_t[d] == 3)
          cur_op[d] = (prog.size() > 0) ?
                      prog.pop_front() : 4'h0;
        opcode[d] = cur_op[d];
      end
      #1;
      e_con = exp_con(d);
      e_ts  = 6'(1) << (m_t[d] - 1);
      n_vec += 5;
      if (con[d] !== e_con) begin
        n_err++;
        $display("FAIL %s con d%0d: got %h want %h",
                 tag, d, con[d], e_con);
      end
      if (ts[d] !== e_ts) begin
        n_err++;
        $display("FAIL %s tstate d%0d: got %b want %b",
                 tag, d, ts[d], e_ts);
      end
      if (halt[d] !== m_halt[d]) begin
        n_err++;
        $display("FAIL %s halt d%0d: got %b want %b",
                 tag, d, halt[d], m_halt[d]);
      end
      if (ill[d] !== m_ill[d]) begin
        n_err++;
        $display("FAIL %s illegal d%0d: got %b want %b",
                 tag, d, ill[d], m_ill[d]);
      end
      if (cnt[d] !== m_cnt[d]) begin
        n_err++;
        $display("FAIL %s count d%0d: got %0d want %0d",
                 tag, d, cnt[d], m_cnt[d]);
      end
      n_vec++;
      if ($countones(con[d] & DRV) > 1) begin
        n_err++;
        $display("FAIL %s bus d%0d: got %h want <=1 driver",
                 tag, d, con[d]);
      end
      @(posedge clk);
      model_step(d);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    clear_n[0] = 1'b0;
    model_reset(0);
    repeat (3) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (con[0] !== 12'h000 || ts[0] !== 6'b000001 ||
          halt[0] !== 1'b0 || cnt[0] !== 8'd0 ||
          ill[0] !== 1'b0) begin
        n_err++;
        $display("FAIL reset: got con=%h ts=%b h=%b c=%0d",
                 con[0], ts[0], halt[0], cnt[0]);
        $display("  want con=000 ts=000001 h=0 c=0");
      end
    end
    @(negedge clk);
    clear_n[0] = 1'b1;
    opcode[0]  = 4'h5;
    #1;
    n_vec++;
    if (con[0] !== (B_EP | B_LM)) begin
      n_err++;
      $display("FAIL reset_c1: got %h want %h",
               con[0], B_EP | B_LM);
    end
    @(posedge clk);
    model_step(0);
    @(negedge clk);
    #1;
    n_vec++;
    if (con[0] !== B_CP) begin
      n_err++;
      $display("FAIL reset_c2: got %h want %h",
               con[0], B_CP);
    end
    @(negedge clk);
  endtask

  task automatic test_add;
    do_reset(0, 2);
    prog.push_back(4'h1);
    run_cycles(0, 5, "add");
    #1;
    n_vec++;
    if (con[0] !== (B_EU | B_LA) || cnt[0] !== 8'd0) begin
      n_err++;
      $display("FAIL add_t6: got %h/%0d want %h/0",
               con[0], cnt[0], B_EU | B_LA);
    end
    run_cycles(0, 1, "add");
    n_vec++;
    if (cnt[0] !== 8'd1 || ts[0] !== 6'b000001) begin
      n_err++;
      $display("FAIL add_end: got %0d/%b want 1/000001",
               cnt[0], ts[0]);
    end
  endtask

  task automatic test_early;
    do_reset(1, 2);
    prog.push_back(4'h2);
    prog.push_back(4'h0);
    prog.push_back(4'hE);
    run_cycles(1, 5, "early");
    #1;
    n_vec++;
    if (con[1] !== (B_SU | B_EU | B_LA)) begin
      n_err++;
      $display("FAIL sub_t6: got %h want %h",
               con[1], B_SU | B_EU | B_LA);
    end
    run_cycles(1, 6, "early");
    n_vec++;
    if (ts[1] !== 6'b000001 || cnt[1] !== 8'd2) begin
      n_err++;
      $display("FAIL lda_early: got %b/%0d want 000001/2",
               ts[1], cnt[1]);
    end
    run_cycles(1, 3, "early");
    #1;
    n_vec++;
    if (con[1] !== (B_EA | B_LO)) begin
      n_err++;
      $display("FAIL out_t4: got %h want %h",
               con[1], B_EA | B_LO);
    end
    run_cycles(1, 1, "early");
    n_vec++;
    if (ts[1] !== 6'b000001 || cnt[1] !== 8'd3) begin
      n_err++;
      $display("FAIL out_early: got %b/%0d want 000001/3",
               ts[1], cnt[1]);
    end
  endtask

  task automatic test_hlt;
    do_reset(0, 2);
    prog.push_back(4'hF);
    run_cycles(0, 4, "hlt");
    #1;
    n_vec++;
    if (halt[0] !== 1'b1 || ts[0] !== 6'b001000 ||
        con[0] !== 12'h000 || cnt[0] !== 8'd1) begin
      n_err++;
      $display("FAIL hlt: got h=%b ts=%b con=%h c=%0d",
               halt[0], ts[0], con[0], cnt[0]);
      $display("  want h=1 ts=001000 con=000 c=1");
    end
    run_cycles(0, 10, "halted");
    clear_n[0] = 1'b0;
    model_reset(0);
    #1;
    n_vec++;
    if (halt[0] !== 1'b0 || ts[0] !== 6'b000001) begin
      n_err++;
      $display("FAIL hlt_clear: got %b/%b want 0/000001",
               halt[0], ts[0]);
    end
    @(negedge clk);
    clear_n[0] = 1'b1;
  endtask

  task automatic test_illegal;
    do_reset(0, 2);
    prog.push_back(4'h5);
    prog.push_back(4'h0);
    run_cycles(0, 3, "illegal");
    #1;
    n_vec++;
    if (con[0] !== 12'h000) begin
      n_err++;
      $display("FAIL ill_t4: got %h want 000", con[0]);
    end
    run_cycles(0, 9, "illegal");
    n_vec++;
    if (ill[0] !== 1'b1 || cnt[0] !== 8'd2) begin
      n_err++;
      $display("FAIL ill_sticky: got %b/%0d want 1/2",
               ill[0], cnt[0]);
    end
  endtask

  task automatic test_mid_reset;
    do_reset(0, 2);
    prog.push_back(4'h1);
    run_cycles(0, 4, "midrst");
    #1;
    n_vec++;
    if (con[0] !== (B_CE | B_LB) ||
        ts[0] !== 6'b010000) begin
      n_err++;
      $display("FAIL mid_t5: got %h/%b want %h/010000",
               con[0], ts[0], B_CE | B_LB);
    end
    clear_n[0] = 1'b0;
    model_reset(0);
    #1;
    n_vec++;
    if (ts[0] !== 6'b000001 || cnt[0] !== 8'd0 ||
        con[0] !== 12'h000) begin
      n_err++;
      $display("FAIL mid_abort: got %b/%0d/%h want 000001/0/000",
               ts[0], cnt[0], con[0]);
    end
    @(negedge clk);
    clear_n[0] = 1'b1;
    prog.push_back(4'h1);
    run_cycles(0, 6, "midrst");
    n_vec++;
    if (cnt[0] !== 8'd1) begin
      n_err++;
      $display("FAIL mid_after: got %0d want 1", cnt[0]);
    end
  endtask

  task automatic test_wrap;
    do_reset(1, 2);
    repeat (256) prog.push_back(4'hE);
    run_cycles(1, 255 * 4, "wrap");
    n_vec++;
    if (cnt[1] !== 8'd255) begin
      n_err++;
      $display("FAIL wrap_255: got %0d want 255", cnt[1]);
    end
    run_cycles(1, 4, "wrap");
    n_vec++;
    if (cnt[1] !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_0: got %0d want 0", cnt[1]);
    end
  endtask

  task automatic test_random(input int d);
    int          total;
    int          nops;
    logic [3:0]  op;
    logic [7:0]  want;
    do_reset(d, 2);
    total = 0;
    nops  = 24;
    for (int i = 0; i < nops; i++) begin
      op = 4'($urandom_range(0, 14));
      prog.push_back(op);
      total += last_t(op, d);
    end
    run_cycles(d, total, "random");
    want = 8'(nops);
    n_vec++;
    if (cnt[d] !== want || ts[d] !== 6'b000001) begin
      n_err++;
      $display("FAIL random d%0d: got %0d/%b want %0d/000001",
               d, cnt[d], ts[d], want);
    end
  endtask

  initial begin
    clear_n[0] = 1'b0;
    clear_n[1] = 1'b0;
    opcode[0]  = 4'h0;
    opcode[1]  = 4'h0;
    cur_op[0]  = 4'h0;
    cur_op[1]  = 4'h0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    test_reset;
    test_add;
    test_early;
    test_hlt;
    test_illegal;
    test_mid_reset;
    test_wrap;
    test_random(0);
    test_random(1);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
